// File: rtl/shift_nbit_seq.sv
// Sequential log-stage shifter.
// One shift stage of distance 2^stage is applied per clock. The RUN phase
// always lasts SHIFT_WIDTH cycles, so the result latency does not depend on
// the shift amount. Only one operation is in flight at a time, with a
// valid/ready handshake on both the operand side and the result side.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid
// RUN   | applying one log-stage per clock, stage 0..SHIFT_WIDTH-1
// DONE  | out_valid high, Y holds the result until out_ready
module shift_nbit_seq #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SHIFT_WIDTH-1:0] LAST_STAGE = SHIFT_WIDTH'(SHIFT_WIDTH - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WIDTH-1:0]       r_data;
  logic [WIDTH-1:0]       r_y;
  logic [SHIFT_WIDTH-1:0] r_amt;
  logic [SHIFT_WIDTH-1:0] r_stage;
  logic [1:0]             r_mode;

  logic                   w_accept;
  logic                   w_last_stage;
  logic                   w_amt_bit;
  logic [WIDTH-1:0]       w_stage_shift;
  logic [2*WIDTH-1:0]     w_rot;
  logic [WIDTH-1:0]       w_data_next;
  logic                   w_unused_b;

  // Upper shift-amount bits are deliberately ignored.
  assign w_unused_b = ^B;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake qualification.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last_stage = (r_stage == LAST_STAGE);
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last_stage) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // One stage of shifting, distance 2^r_stage, selected by the captured mode.
  // Arithmetic right relies on the current MSB still equalling the captured
  // sign bit, which every earlier SRA stage preserves.
  always_comb begin
    w_stage_shift = r_data;
    w_rot         = '0;
    w_amt_bit     = 1'b0;
    for (int k = 0; k < SHIFT_WIDTH; k++) begin
      if (r_stage == SHIFT_WIDTH'(k)) begin
        w_amt_bit = r_amt[k];
        w_rot     = {r_data, r_data} >> (1 << k);
        case (r_mode)
          2'b00:   w_stage_shift = r_data << (1 << k);
          2'b01:   w_stage_shift = r_data >> (1 << k);
          2'b10:   w_stage_shift = $signed(r_data) >>> (1 << k);
          default: w_stage_shift = w_rot[WIDTH-1:0];
        endcase
      end
    end
    w_data_next = w_amt_bit ? w_stage_shift : r_data;
  end

  // Operand capture, stage stepping and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_amt   <= '0;
      r_mode  <= 2'b00;
      r_stage <= '0;
      r_y     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= A;
            r_amt   <= B[SHIFT_WIDTH-1:0];
            r_mode  <= mode;
            r_stage <= '0;
          end
        end
        RUN: begin
          r_data <= w_data_next;
          if (w_last_stage) begin
            r_y     <= w_data_next;
            r_stage <= '0;
          end else begin
            r_stage <= r_stage + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign Y         = r_y;

endmodule

// File: tb/tb_shift_nbit_seq.sv
// Bench for shift_nbit_seq: an 8-bit instance driven from a vector table with
// a result scoreboard, plus a 32-bit instance for the wide-parameter cases.
module tb_shift_nbit_seq;

  localparam int W  = 8;
  localparam int SW = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  A, B, Y;
  logic [1:0]  mode;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, busy_w;
  logic [31:0] A_w, B_w, Y_w;
  logic [1:0]  mode_w;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] m;
    logic [7:0] y;
  } vec_t;

  vec_t vecs[$];

  shift_nbit_seq #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .busy(busy)
  );

  shift_nbit_seq #(.WIDTH(32), .SHIFT_WIDTH(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .A(A_w), .B(B_w), .mode(mode_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .Y(Y_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: pops the scoreboard on every output handshake and flags
  // any out_valid that has no matching accepted operation behind it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("stale_out_valid", {31'd0, out_valid}, 32'd0);
        end else if (out_ready) begin
          sb_exp = sb.pop_front();
          check("result_Y", {24'd0, Y}, {24'd0, sb_exp});
        end
      end
    end
  end

  // Drive one op, wait for acceptance, push the expectation, check the
  // fixed latency. Returns at the first negedge with out_valid high.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] m, input logic [7:0] y);
    int n;
    in_valid = 1'b1;
    A = a; B = b; mode = m;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(y);
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = ~b; mode = ~m;
    for (int i = 0; i < SW; i++) begin
      check("latency_low", {31'd0, out_valid}, 32'd0);
      check("busy_run", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("latency_high", {31'd0, out_valid}, 32'd1);
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic [31:0] y);
    int n;
    in_valid_w = 1'b1;
    A_w = a; B_w = b; mode_w = m;
    n = 0;
    while (!in_ready_w && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_w = 1'b0;
    A_w = ~a;
    for (int i = 0; i < 5; i++) begin
      check("w32_latency_low", {31'd0, out_valid_w}, 32'd0);
      @(negedge clk);
    end
    check("w32_latency_high", {31'd0, out_valid_w}, 32'd1);
    check("w32_Y", Y_w, y);
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
    check("w32_out_valid_drop", {31'd0, out_valid_w}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{8'h96, 8'h03, 2'b10, 8'hF2});
    vecs.push_back('{8'h96, 8'h03, 2'b01, 8'h12});
    vecs.push_back('{8'h96, 8'hFB, 2'b00, 8'hB0});
    vecs.push_back('{8'h96, 8'hFB, 2'b11, 8'hD2});
    vecs.push_back('{8'h80, 8'h07, 2'b10, 8'hFF});
    vecs.push_back('{8'h80, 8'h00, 2'b10, 8'h80});
    vecs.push_back('{8'h01, 8'h07, 2'b00, 8'h80});
    vecs.push_back('{8'h96, 8'h05, 2'b11, 8'hB4});
    vecs.push_back('{8'hFF, 8'h01, 2'b00, 8'hFE});
    vecs.push_back('{8'h81, 8'h07, 2'b01, 8'h01});
    vecs.push_back('{8'h7F, 8'h04, 2'b10, 8'h07});

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; mode = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; A_w = '0; B_w = '0; mode_w = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_Y", {24'd0, Y}, 32'd0);
    check("rst_Y_w32", Y_w, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].y);
      finish_op();
    end

    // Backpressure with ignored in_valid pulses, then a request that overlaps
    // the result handshake and must only be taken once in_ready returns.
    start_op(8'h96, 8'h03, 2'b10, 8'hF2);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      A = 8'($urandom);
      B = 8'($urandom);
      @(negedge clk);
      check("bp_Y", {24'd0, Y}, 32'h0000_00F2);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b1;
    A = 8'h01; B = 8'h07; mode = 2'b00;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("overlap_not_taken", {31'd0, in_ready}, 32'd1);
    check("overlap_busy", {31'd0, busy}, 32'd0);
    check("Y_held_after_hs", {24'd0, Y}, 32'h0000_00F2);
    start_op(8'h01, 8'h07, 2'b00, 8'h80);
    finish_op();

    // Reset during RUN stage 1 discards the operation.
    in_valid = 1'b1;
    A = 8'h96; B = 8'h03; mode = 2'b10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_Y", {24'd0, Y}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    start_op(8'h96, 8'h03, 2'b01, 8'h12);
    finish_op();

    run32(32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF);
    run32(32'h0000_0001, 32'd1, 2'b11, 32'h8000_0000);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
